// File: rtl/dual_port_mem_responder.sv
// Memory-side responder for the CPU instruction and data ports.
// Both ports share one word array, each access has a fixed latency, and the ports are served round robin.
module dual_port_mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_readM,
  input  logic                 i_writeM,
  input  logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 d_ready,
  output logic                 busy,
  output logic                 protocol_err,
  output logic [15:0]          access_count
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_e;

  localparam logic       PORT_I       = 1'b0;
  localparam logic       PORT_D       = 1'b1;
  localparam logic [3:0] CNT_INIT     = 4'(LATENCY - 1);
  localparam logic       SINGLE_CYCLE = (LATENCY == 1);

  state_e                 state_q;
  logic                   port_q, op_q, last_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [WORD_SIZE-1:0]   wdata_q, rdata_q;
  logic [3:0]             cnt_q;
  logic                   i_ready_q, d_ready_q, drive_i_q, drive_d_q;
  logic                   busy_q, perr_q;
  logic [15:0]            count_q;
  logic [WORD_SIZE-1:0]   mem_q [2**ADDR_BITS];

  logic                   pend_i_s, pend_d_s, acc_s, acc_port_s, acc_wr_s, acc_rd_s;
  logic [ADDR_BITS-1:0]   acc_idx_s, done_idx_s;
  logic [WORD_SIZE-1:0]   acc_wdata_s, done_wdata_s;
  logic                   done_go_s, done_port_s, done_op_s;
  logic                   unused_addr_s;

  assign unused_addr_s = ^{i_address, d_address};

  // Arbitration: the port just served is masked at the edge that ends DONE.
  always_comb begin
    pend_i_s   = 1'b0;
    pend_d_s   = 1'b0;
    acc_s      = 1'b0;
    acc_port_s = PORT_I;
    if (state_q == ST_IDLE || state_q == ST_DONE) begin
      pend_i_s = (i_readM | i_writeM) & ~(state_q == ST_DONE && port_q == PORT_I);
      pend_d_s = (d_readM | d_writeM) & ~(state_q == ST_DONE && port_q == PORT_D);
    end else begin
      pend_i_s = 1'b0;
      pend_d_s = 1'b0;
    end
    if (pend_i_s && pend_d_s) begin
      acc_s      = 1'b1;
      acc_port_s = ~last_q;
    end else if (pend_d_s) begin
      acc_s      = 1'b1;
      acc_port_s = PORT_D;
    end else if (pend_i_s) begin
      acc_s      = 1'b1;
      acc_port_s = PORT_I;
    end else begin
      acc_s      = 1'b0;
      acc_port_s = PORT_I;
    end
  end

  assign acc_wr_s    = (acc_port_s == PORT_D) ? d_writeM : i_writeM;
  assign acc_rd_s    = (acc_port_s == PORT_D) ? d_readM  : i_readM;
  assign acc_idx_s   = (acc_port_s == PORT_D) ? d_address[ADDR_BITS-1:0] : i_address[ADDR_BITS-1:0];
  assign acc_wdata_s = (acc_port_s == PORT_D) ? d_data : i_data;

  // DONE-entry selection: with unit latency the access completes on its own accept edge.
  always_comb begin
    done_go_s    = 1'b0;
    done_port_s  = port_q;
    done_op_s    = op_q;
    done_idx_s   = idx_q;
    done_wdata_s = wdata_q;
    if (state_q == ST_BUSY && cnt_q == 4'd1) begin
      done_go_s = 1'b1;
    end else if (SINGLE_CYCLE && acc_s) begin
      done_go_s    = 1'b1;
      done_port_s  = acc_port_s;
      done_op_s    = acc_wr_s;
      done_idx_s   = acc_idx_s;
      done_wdata_s = acc_wdata_s;
    end else begin
      done_go_s = 1'b0;
    end
  end

  // Control FSM, latency counter, ready pulses, bus-drive enables and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      port_q    <= PORT_I;
      op_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      last_q    <= PORT_I;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      drive_i_q <= 1'b0;
      drive_d_q <= 1'b0;
      busy_q    <= 1'b0;
      perr_q    <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      i_ready_q <= done_go_s && (done_port_s == PORT_I);
      d_ready_q <= done_go_s && (done_port_s == PORT_D);
      if (acc_s) begin
        port_q  <= acc_port_s;
        op_q    <= acc_wr_s;
        idx_q   <= acc_idx_s;
        wdata_q <= acc_wdata_s;
        cnt_q   <= CNT_INIT;
        last_q  <= acc_port_s;
        if (acc_wr_s && acc_rd_s) perr_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          state_q <= acc_s ? (SINGLE_CYCLE ? ST_DONE : ST_BUSY) : ST_IDLE;
          busy_q  <= acc_s;
        end
        ST_BUSY: begin
          cnt_q   <= cnt_q - 4'd1;
          state_q <= (cnt_q == 4'd1) ? ST_DONE : ST_BUSY;
          busy_q  <= 1'b1;
        end
        ST_DONE: begin
          count_q <= count_q + 16'd1;
          state_q <= acc_s ? (SINGLE_CYCLE ? ST_DONE : ST_BUSY) : ST_IDLE;
          busy_q  <= acc_s;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (done_go_s && !done_op_s && done_port_s == PORT_I) drive_i_q <= 1'b1;
      else if (!i_readM || (acc_s && acc_port_s == PORT_I)) drive_i_q <= 1'b0;
      if (done_go_s && !done_op_s && done_port_s == PORT_D) drive_d_q <= 1'b1;
      else if (!d_readM || (acc_s && acc_port_s == PORT_D)) drive_d_q <= 1'b0;
    end
  end

  // Word array and read capture; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (reset_n && done_go_s && done_op_s) mem_q[done_idx_s] <= done_wdata_s;
    if (reset_n && done_go_s && !done_op_s) rdata_q <= mem_q[done_idx_s];
  end

  assign i_data       = (drive_i_q && i_readM && !i_writeM) ? rdata_q : {WORD_SIZE{1'bz}};
  assign d_data       = (drive_d_q && d_readM && !d_writeM) ? rdata_q : {WORD_SIZE{1'bz}};
  assign i_ready      = i_ready_q;
  assign d_ready      = d_ready_q;
  assign busy         = busy_q;
  assign protocol_err = perr_q;
  assign access_count = count_q;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Self-checking bench for dual_port_mem_responder: table-driven single accesses plus hand sequences
// for protocol error, round-robin alternation, streaming throughput and reset abort.
module tb_dual_port_mem_responder;

  localparam int LAT = 3;

  typedef struct {
    bit          port;   // 0 = instruction, 1 = data
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_readM, i_writeM, d_readM, d_writeM;
  logic [15:0] i_address, d_address;
  wire  [15:0] i_data, d_data;
  logic        i_ready, d_ready, busy, protocol_err;
  logic [15:0] access_count;
  logic        tb_i_oe, tb_d_oe;
  logic [15:0] tb_i_out, tb_d_out;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  vec_t        vecs[12];

  assign i_data = tb_i_oe ? tb_i_out : 16'hzzzz;
  assign d_data = tb_d_oe ? tb_d_out : 16'hzzzz;

  always #5 clk = ~clk;

  dual_port_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_readM(i_readM), .i_writeM(i_writeM), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_data(d_data), .d_ready(d_ready),
    .busy(busy), .protocol_err(protocol_err), .access_count(access_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] bus_of(input bit port);
    return port ? d_data : i_data;
  endfunction

  function automatic logic ready_of(input bit port);
    return port ? d_ready : i_ready;
  endfunction

  // One complete access from IDLE: latency, read data, hold while readM stays high, release after.
  task automatic run_access(input vec_t v);
    int   n;
    logic got;
    logic [15:0] e;
    @(negedge clk);
    if (v.port) begin
      d_address = v.addr;
      if (v.wr) begin d_writeM = 1'b1; tb_d_oe = 1'b1; tb_d_out = v.wdata; end
      else d_readM = 1'b1;
    end else begin
      i_address = v.addr;
      if (v.wr) begin i_writeM = 1'b1; tb_i_oe = 1'b1; tb_i_out = v.wdata; end
      else i_readM = 1'b1;
    end
    if (!v.wr) exp_q.push_back(v.exp);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = ready_of(v.port);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout port=%0d addr=%h actual=no_ready required=ready", v.port, v.addr);
      if (!v.wr) void'(exp_q.pop_front());
    end else begin
      check("latency", 32'(n), 32'(LAT));
      if (!v.wr) begin
        e = exp_q.pop_front();
        check("read_data", {16'h0, bus_of(v.port)}, {16'h0, e});
      end
    end
    if (v.wr) begin
      i_writeM = 1'b0; d_writeM = 1'b0; tb_i_oe = 1'b0; tb_d_oe = 1'b0;
    end else begin
      @(negedge clk);
      check("read_hold", {16'h0, bus_of(v.port)}, {16'h0, v.exp});
      i_readM = 1'b0; d_readM = 1'b0;
      #1;
      if (v.port) begin tb_d_oe = 1'b1; tb_d_out = ~v.exp; end
      else begin tb_i_oe = 1'b1; tb_i_out = ~v.exp; end
      #1;
      check("read_release", {16'h0, bus_of(v.port)}, {16'h0, ~v.exp});
      tb_i_oe = 1'b0; tb_d_oe = 1'b0;
    end
  endtask

  initial begin
    int          n, k, prev, nready;
    logic        got, exp_port;
    logic [15:0] stream_exp[4];

    vecs[0]  = '{1'b1, 1'b1, 16'h0110, 16'h1234, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234};
    vecs[2]  = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF};
    vecs[4]  = '{1'b0, 1'b1, 16'h0040, 16'hA000, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 16'h0041, 16'hA111, 16'h0000};
    vecs[6]  = '{1'b1, 1'b1, 16'h0042, 16'hA222, 16'h0000};
    vecs[7]  = '{1'b1, 1'b1, 16'h0043, 16'hA333, 16'h0000};
    vecs[8]  = '{1'b1, 1'b1, 16'h0030, 16'h7777, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 16'h0130, 16'h0000, 16'h7777};
    vecs[10] = '{1'b0, 1'b0, 16'hFF05, 16'h0000, 16'hBEEF};
    vecs[11] = '{1'b0, 1'b0, 16'h0142, 16'h0000, 16'hA222};
    stream_exp[0] = 16'hA000; stream_exp[1] = 16'hA111;
    stream_exp[2] = 16'hA222; stream_exp[3] = 16'hA333;

    reset_n = 1'b0;
    i_readM = 1'b0; i_writeM = 1'b0; d_readM = 1'b0; d_writeM = 1'b0;
    i_address = 16'h0; d_address = 16'h0;
    tb_i_oe = 1'b0; tb_d_oe = 1'b0; tb_i_out = 16'h0; tb_d_out = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_i_ready", {31'h0, i_ready}, 32'h0);
    check("rst_d_ready", {31'h0, d_ready}, 32'h0);
    check("rst_perr", {31'h0, protocol_err}, 32'h0);
    check("rst_count", {16'h0, access_count}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_access(vecs[i]);
      if (i == 1) check("count_after_2", {16'h0, access_count}, 32'd2);
    end
    check("count_after_table", {16'h0, access_count}, 32'd12);

    // readM and writeM together on the data port: treated as a write, error flag is sticky.
    @(negedge clk);
    d_address = 16'h0020; d_readM = 1'b1; d_writeM = 1'b1; tb_d_oe = 1'b1; tb_d_out = 16'h00AA;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin @(negedge clk); n++; got = d_ready; end
    check("perr_latency", 32'(n), 32'(LAT));
    d_readM = 1'b0; d_writeM = 1'b0; tb_d_oe = 1'b0;
    check("perr_set", {31'h0, protocol_err}, 32'h1);
    run_access('{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h00AA});
    check("perr_sticky", {31'h0, protocol_err}, 32'h1);
    check("count_after_perr", {16'h0, access_count}, 32'd14);

    // Reset during BUSY of a write aborts it without a ready pulse or array update.
    @(negedge clk);
    d_address = 16'h0030; d_writeM = 1'b1; tb_d_oe = 1'b1; tb_d_out = 16'h1111;
    @(negedge clk);
    check("abort_busy_before", {31'h0, busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("abort_busy_now", {31'h0, busy}, 32'h0);
    d_writeM = 1'b0; tb_d_oe = 1'b0;
    k = 0;
    repeat (3) begin @(negedge clk); k += int'(d_ready); end
    check("abort_no_ready", 32'(k), 32'd0);
    reset_n = 1'b1;
    check("abort_perr_cleared", {31'h0, protocol_err}, 32'h0);
    check("abort_count_cleared", {16'h0, access_count}, 32'h0);
    run_access('{1'b0, 1'b0, 16'h0030, 16'h0000, 16'h7777});
    check("count_after_abort", {16'h0, access_count}, 32'd1);

    // Both ports reading continuously: D first (last served I), then strict alternation every LAT cycles.
    @(negedge clk);
    i_address = 16'h0005; d_address = 16'h0010; i_readM = 1'b1; d_readM = 1'b1;
    exp_port = 1'b1; prev = -1; nready = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (i_ready && d_ready) check("alt_both_ready", 32'h1, 32'h0);
      if (i_ready || d_ready) begin
        check("alt_port", {31'h0, d_ready}, {31'h0, exp_port});
        check("alt_data", {16'h0, d_ready ? d_data : i_data}, {16'h0, d_ready ? 16'h1234 : 16'hBEEF});
        if (prev >= 0) check("alt_gap", 32'(c - prev), 32'(LAT));
        prev = c; exp_port = ~exp_port; nready++;
      end
    end
    check("alt_count", 32'(nready), 32'd6);
    i_readM = 1'b0; d_readM = 1'b0;
    n = 0;
    while (busy && n < 10) begin @(negedge clk); n++; end
    check("alt_drain", {31'h0, busy}, 32'h0);

    // Single port streaming: address stepped at each ready, one completion every LAT+1 cycles.
    @(negedge clk);
    i_address = 16'h0040; i_readM = 1'b1;
    exp_q.push_back(stream_exp[0]);
    k = 0; n = 0; prev = -1;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (i_ready) begin
        check("stream_data", {16'h0, i_data}, {16'h0, exp_q.pop_front()});
        if (prev >= 0) check("stream_gap", 32'(n - prev), 32'(LAT + 1));
        prev = n; k++;
        if (k < 4) begin
          i_address = 16'h0040 + 16'(k);
          exp_q.push_back(stream_exp[k]);
        end else begin
          i_readM = 1'b0;
        end
      end
    end
    check("stream_completions", 32'(k), 32'd4);
    i_readM = 1'b0;
    repeat (2) @(negedge clk);
    check("final_idle", {31'h0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
